// File: rtl/pe_pass_sequencer.sv
// Runs one full PE pass: config load, filter/ifmap/ipsum streaming from a single-port GLB, opsum write-back.
// Optional stall-cycle counter on perf_cycles is built only when PE_SEQ_PERF_EN is defined.
module pe_pass_sequencer #(
  parameter int DATA_BITS   = 32,
  parameter int CONFIG_SIZE = 13,
  parameter int ADDR_W      = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CONFIG_SIZE-1:0] cfg,
  input  logic [ADDR_W-1:0]      filter_base,
  input  logic [ADDR_W-1:0]      ifmap_base,
  input  logic [ADDR_W-1:0]      ipsum_base,
  input  logic [ADDR_W-1:0]      opsum_base,
  output logic                   busy,
  output logic                   done,
  output logic                   pe_en,
  output logic [CONFIG_SIZE-1:0] pe_config,
  output logic [DATA_BITS-1:0]   pe_filter,
  output logic [DATA_BITS-1:0]   pe_ifmap,
  output logic [DATA_BITS-1:0]   pe_ipsum,
  output logic                   pe_filter_valid,
  output logic                   pe_ifmap_valid,
  output logic                   pe_ipsum_valid,
  input  logic                   pe_filter_ready,
  input  logic                   pe_ifmap_ready,
  input  logic                   pe_ipsum_ready,
  input  logic [DATA_BITS-1:0]   pe_opsum,
  input  logic                   pe_opsum_valid,
  output logic                   pe_opsum_ready,
  output logic [ADDR_W-1:0]      glb_addr,
  output logic                   glb_ren,
  input  logic [DATA_BITS-1:0]   glb_rdata,
  output logic                   glb_wen,
  output logic [DATA_BITS-1:0]   glb_wdata,
  output logic [15:0]            perf_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_FILTER, S_IFMAP, S_IPSUM, S_OPSUM, S_DONE} state_t;
  typedef enum logic {PH_FETCH, PH_HOLD} phase_t;

  localparam logic [ADDR_W-1:0] A_ONE = 1;

  state_t                 state_q, state_d, rd_next;
  phase_t                 phase_q, phase_d;
  logic                   fresh_q, fresh_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic [CONFIG_SIZE-1:0] cfg_q, cfg_d;
  logic [ADDR_W-1:0]      fbase_q, fbase_d, ibase_q, ibase_d, pbase_q, pbase_d, obase_q, obase_d;
  logic [ADDR_W-1:0]      fptr_q, fptr_d, iptr_q, iptr_d, pptr_q, pptr_d, optr_q, optr_d;
  logic [4:0]             cnt_q, cnt_d, col_q, col_d;
  logic                   ren_c, wen_c;

  logic [4:0]        rs_w, u_w, p_w, q_w, filt_n, ifm_n, ps_n, rd_target;
  logic [ADDR_W-1:0] rd_base, rd_ptr;
  logic              rd_rdy, rd_vld;
  logic [DATA_BITS-1:0] rd_dat;

  assign rs_w   = 5'(cfg_q[11:10]) + 5'd1;
  assign u_w    = 5'(cfg_q[9]) + 5'd1;
  assign p_w    = 5'(cfg_q[8:7]) + 5'd1;
  assign q_w    = 5'(cfg_q[1:0]) + 5'd1;
  assign filt_n = p_w * rs_w;
  assign ifm_n  = (col_q == 5'd0) ? rs_w : u_w;
  assign ps_n   = cfg_q[12] ? q_w : p_w;

  // Shared read engine: select base/pointer/quota/ready of the active stream.
  always_comb begin
    rd_base   = fbase_q;
    rd_ptr    = fptr_q;
    rd_target = filt_n;
    rd_rdy    = pe_filter_ready;
    rd_next   = S_IFMAP;
    case (state_q)
      S_IFMAP: begin
        rd_base = ibase_q; rd_ptr = iptr_q; rd_target = ifm_n;
        rd_rdy = pe_ifmap_ready; rd_next = S_IPSUM;
      end
      S_IPSUM: begin
        rd_base = pbase_q; rd_ptr = pptr_q; rd_target = ps_n;
        rd_rdy = pe_ipsum_ready; rd_next = S_OPSUM;
      end
      default: ;
    endcase
  end

  assign rd_vld = (phase_q == PH_HOLD) &&
                  (state_q == S_FILTER || state_q == S_IFMAP || state_q == S_IPSUM);
  // First HOLD cycle forwards the GLB return directly; later cycles use the captured copy.
  assign rd_dat = fresh_q ? glb_rdata : hold_q;

  always_comb begin
    state_d = state_q;  phase_d = phase_q;  fresh_d = 1'b0;  hold_d = hold_q;
    cfg_d   = cfg_q;    fbase_d = fbase_q;  ibase_d = ibase_q;
    pbase_d = pbase_q;  obase_d = obase_q;
    fptr_d  = fptr_q;   iptr_d  = iptr_q;   pptr_d  = pptr_q;  optr_d = optr_q;
    cnt_d   = cnt_q;    col_d   = col_q;
    ren_c   = 1'b0;     wen_c   = 1'b0;
    glb_addr = '0;      glb_wdata = '0;     pe_opsum_ready = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        cfg_d = cfg;  fbase_d = filter_base;  ibase_d = ifmap_base;
        pbase_d = ipsum_base;  obase_d = opsum_base;
        fptr_d = '0;  iptr_d = '0;  pptr_d = '0;  optr_d = '0;
        cnt_d = '0;   col_d = '0;   phase_d = PH_FETCH;
        state_d = S_CFG;
      end
      S_CFG: state_d = S_FILTER;
      S_FILTER, S_IFMAP, S_IPSUM: begin
        if (phase_q == PH_FETCH) begin
          ren_c    = 1'b1;
          glb_addr = rd_base + rd_ptr;
          phase_d  = PH_HOLD;
          fresh_d  = 1'b1;
        end else begin
          if (fresh_q) hold_d = glb_rdata;
          if (rd_rdy) begin
            case (state_q)
              S_FILTER: fptr_d = fptr_q + A_ONE;
              S_IFMAP:  iptr_d = iptr_q + A_ONE;
              default:  pptr_d = pptr_q + A_ONE;
            endcase
            phase_d = PH_FETCH;
            if (cnt_q + 5'd1 == rd_target) begin
              cnt_d   = '0;
              state_d = rd_next;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
      end
      S_OPSUM: begin
        pe_opsum_ready = 1'b1;
        if (pe_opsum_valid) begin
          wen_c     = 1'b1;
          glb_addr  = obase_q + optr_q;
          glb_wdata = pe_opsum;
          optr_d    = optr_q + A_ONE;
          if (cnt_q + 5'd1 == ps_n) begin
            cnt_d = '0;
            if (col_q == cfg_q[6:2]) begin
              state_d = S_DONE;
            end else begin
              col_d   = col_q + 5'd1;
              state_d = S_IFMAP;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;  phase_q <= PH_FETCH;  fresh_q <= 1'b0;  hold_q <= '0;
      cfg_q   <= '0;      fbase_q <= '0;  ibase_q <= '0;  pbase_q <= '0;  obase_q <= '0;
      fptr_q  <= '0;      iptr_q  <= '0;  pptr_q  <= '0;  optr_q  <= '0;
      cnt_q   <= '0;      col_q   <= '0;
    end else begin
      state_q <= state_d;  phase_q <= phase_d;  fresh_q <= fresh_d;  hold_q <= hold_d;
      cfg_q   <= cfg_d;    fbase_q <= fbase_d;  ibase_q <= ibase_d;
      pbase_q <= pbase_d;  obase_q <= obase_d;
      fptr_q  <= fptr_d;   iptr_q  <= iptr_d;   pptr_q  <= pptr_d;  optr_q <= optr_d;
      cnt_q   <= cnt_d;    col_q   <= col_d;
    end
  end

  // A pass being aborted by rst must not touch the GLB in that cycle.
  assign glb_ren = ren_c & ~rst;
  assign glb_wen = wen_c & ~rst;

  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign pe_en           = (state_q == S_CFG);
  assign pe_config       = cfg_q;
  assign pe_filter       = rd_dat;
  assign pe_ifmap        = rd_dat;
  assign pe_ipsum        = rd_dat;
  assign pe_filter_valid = rd_vld && (state_q == S_FILTER);
  assign pe_ifmap_valid  = rd_vld && (state_q == S_IFMAP);
  assign pe_ipsum_valid  = rd_vld && (state_q == S_IPSUM);

`ifdef PE_SEQ_PERF_EN
  logic [15:0] perf_q;
  logic        stall;
  assign stall = busy && ((pe_filter_valid && !pe_filter_ready) ||
                          (pe_ifmap_valid  && !pe_ifmap_ready)  ||
                          (pe_ipsum_valid  && !pe_ipsum_ready)  ||
                          (pe_opsum_valid  && !pe_opsum_ready));
  always_ff @(posedge clk) begin
    if (rst)                                 perf_q <= '0;
    else if (state_q == S_IDLE && start)     perf_q <= '0;
    else if (stall && perf_q != 16'hFFFF)    perf_q <= perf_q + 16'd1;
  end
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule
